// File: rtl/alu_issue.sv
// RV32I OP/OP-IMM decode into a single registered issue slot with valid/ready
// handshakes on both sides and a running count of issued operations.
module alu_issue (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] instr_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [3:0]  alu_op_o,
  output logic [31:0] rs1_data_o,
  output logic [31:0] rs2_data_o,
  output logic        br_unsign_o,
  output logic [4:0]  rd_addr_o,
  output logic        illegal_o,
  output logic [15:0] issue_cnt_o
);

  localparam int unsigned XLEN    = 32;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned RADDR_W = 5;
  localparam int unsigned IMM_W   = 12;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic [OP_W-1:0]    alu_op;
    logic [XLEN-1:0]    rs1;
    logic [XLEN-1:0]    rs2;
    logic               br_unsign;
    logic [RADDR_W-1:0] rd;
    logic               illegal;
  } issue_t;

  logic [6:0]       opcode;
  logic [6:0]       funct7;
  logic [2:0]       funct3;
  logic             is_op;
  logic             is_op_imm;
  logic             legal;
  alu_op_e          op;
  logic [XLEN-1:0]  opb;
  issue_t           dec;

  issue_t           issue_d, issue_q;
  logic             out_valid_d, out_valid_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             in_fire;
  logic             out_fire;

  // rs1 register index is resolved upstream; only its data is consumed here
  logic unused_rs1_field;
  assign unused_rs1_field = ^instr_i[19:15];

  assign opcode    = instr_i[6:0];
  assign funct3    = instr_i[14:12];
  assign funct7    = instr_i[31:25];
  assign is_op     = (opcode == OPC_OP);
  assign is_op_imm = (opcode == OPC_OP_IMM);

  // Opcode/funct decode; for OP-IMM non-shifts funct7 is immediate bits
  always_comb begin
    legal = is_op || is_op_imm;
    op    = ALU_ADD;
    case (funct3)
      3'b000: begin
        if (is_op && funct7 == F7_ALT)        op = ALU_SUB;
        else if (is_op && funct7 != F7_BASE)  legal = 1'b0;
      end
      3'b001: begin
        op = ALU_SLL;
        if (funct7 != F7_BASE) legal = 1'b0;
      end
      3'b010: begin
        op = ALU_SLT;
        if (is_op && funct7 != F7_BASE) legal = 1'b0;
      end
      3'b011: begin
        op = ALU_SLTU;
        if (is_op && funct7 != F7_BASE) legal = 1'b0;
      end
      3'b100: begin
        op = ALU_XOR;
        if (is_op && funct7 != F7_BASE) legal = 1'b0;
      end
      3'b101: begin
        if (funct7 == F7_ALT) begin
          op = ALU_SRA;
        end else begin
          op = ALU_SRL;
          if (funct7 != F7_BASE) legal = 1'b0;
        end
      end
      3'b110: begin
        op = ALU_OR;
        if (is_op && funct7 != F7_BASE) legal = 1'b0;
      end
      default: begin
        op = ALU_AND;
        if (is_op && funct7 != F7_BASE) legal = 1'b0;
      end
    endcase
  end

  // Operand B: register, zero-extended shamt, or sign-extended immediate
  always_comb begin
    if (is_op) begin
      opb = rs2_data_i;
    end else if (funct3 == 3'b001 || funct3 == 3'b101) begin
      opb = XLEN'(instr_i[24:20]);
    end else begin
      opb = {{(XLEN-IMM_W){instr_i[31]}}, instr_i[31:20]};
    end
  end

  // Illegal instructions keep rd but carry zeroed operands
  always_comb begin
    dec         = '0;
    dec.rd      = instr_i[11:7];
    dec.illegal = !legal;
    if (legal) begin
      dec.alu_op    = op;
      dec.rs1       = rs1_data_i;
      dec.rs2       = opb;
      dec.br_unsign = (op == ALU_SLTU);
    end
  end

  assign in_ready_o = !out_valid_q || out_ready_i;
  assign in_fire    = in_valid_i && in_ready_o;
  assign out_fire   = out_valid_q && out_ready_i;

  always_comb begin
    issue_d     = issue_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q + CNT_W'(out_fire);
    if (in_fire) begin
      issue_d     = dec;
      out_valid_d = 1'b1;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      issue_q     <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      issue_q     <= issue_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign alu_op_o    = issue_q.alu_op;
  assign rs1_data_o  = issue_q.rs1;
  assign rs2_data_o  = issue_q.rs2;
  assign br_unsign_o = issue_q.br_unsign;
  assign rd_addr_o   = issue_q.rd;
  assign illegal_o   = issue_q.illegal;
  assign issue_cnt_o = cnt_q;

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 The module SHALL have port clk_i, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-002 The module SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-003 The module SHALL have port in_valid_i, input, 1 bit: instruction and register data are valid.
REQ-004 The module SHALL have port in_ready_o, output, 1 bit: the block accepts input this cycle.
REQ-005 The module SHALL have port instr_i, input, 32 bits: RV32I instruction word.
REQ-006 The module SHALL have port rs1_data_i, input, 32 bits: rs1 register value.
REQ-007 The module SHALL have port rs2_data_i, input, 32 bits: rs2 register value.
REQ-008 The module SHALL have port out_valid_o, output, 1 bit: the issue register holds an operation.
REQ-009 The module SHALL have port out_ready_i, input, 1 bit: the ALU side consumes the operation.
REQ-010 The module SHALL have port alu_op_o, output, 4 bits: ALU select.
REQ-011 The module SHALL have port rs1_data_o, output, 32 bits: operand A.
REQ-012 The module SHALL have port rs2_data_o, output, 32 bits: operand B.
REQ-013 The module SHALL have port br_unsign_o, output, 1 bit: unsigned-compare flag.
REQ-014 The module SHALL have port rd_addr_o, output, 5 bits: destination register, instr[11:7].
REQ-015 The module SHALL have port illegal_o, output, 1 bit: the instruction is not a decodable OP/OP-IMM.
REQ-016 The module SHALL have port issue_cnt_o, output, 16 bits: count of completed output handshakes.

Function
REQ-017 alu_op_o encoding SHALL be: 0 add, 1 sub, 2 sll, 3 slt, 4 sltu, 5 xor, 6 srl, 7 sra, 8 or, 9 and; values 10-15 SHALL never be produced.
REQ-018 Only opcode 0110011 (OP) and 0010011 (OP-IMM) SHALL be legal.
REQ-019 Decode by funct3 SHALL be: 000 add (sub only for OP with funct7=0100000), 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl (funct7=0000000) or sra (funct7=0100000), 110 or, 111 and.
REQ-020 For OP-IMM, funct3=000 SHALL always decode as add, never sub.
REQ-021 OP with funct7 not 0000000, and not 0100000 for funct3 000/101, SHALL be illegal.
REQ-022 For shifts (OP and OP-IMM), funct7 not 0000000/0100000, or 0100000 with funct3=001, SHALL be illegal.
REQ-023 rs1_data_o SHALL equal rs1_data_i.
REQ-024 rs2_data_o for OP SHALL equal rs2_data_i.
REQ-025 rs2_data_o for OP-IMM shifts SHALL be {27'b0, instr[24:20]}.
REQ-026 rs2_data_o for other OP-IMM SHALL be instr[31:20] sign-extended to 32 bits.
REQ-027 br_unsign_o SHALL be 1 only for sltu, and 0 otherwise, including for sra.
REQ-028 An illegal instruction SHALL register as alu_op_o=0, rs1_data_o=0, rs2_data_o=0, br_unsign_o=0, illegal_o=1, and still occupy one output slot.
REQ-029 Registered stage, latency 1: input accepted at edge N SHALL appear on the outputs after edge N.
REQ-030 in_ready_o SHALL be !out_valid_o || out_ready_i, combinational, and SHALL not depend on in_valid_i.
REQ-031 An input transfer SHALL occur when in_valid_i && in_ready_o are high at the clock edge.
REQ-032 An output transfer SHALL occur when out_valid_o && out_ready_i are high at the clock edge.
REQ-033 When out_valid_o=1 and out_ready_i=0, all output data SHALL hold stable and no input SHALL be accepted.
REQ-034 Simultaneous output and input transfer SHALL replace the register contents, keep out_valid_o=1, and sustain full throughput of one per cycle.
REQ-035 Output transfer with no input transfer SHALL clear out_valid_o; data outputs SHALL be don't-care but SHALL hold their last value.
REQ-036 issue_cnt_o SHALL increment by 1 on each output transfer, including illegal ones, and SHALL wrap from 0xFFFF to 0x0000.

Reset
REQ-037 rst_i=1 SHALL immediately, without a clock, force out_valid_o=0, alu_op_o=0, rs1_data_o=0, rs2_data_o=0, br_unsign_o=0, rd_addr_o=0, illegal_o=0, issue_cnt_o=0.
REQ-038 Reset asserted mid-stall SHALL discard the held operation without counting it.
REQ-039 While rst_i=1, in_ready_o SHALL be 1 but no transfer SHALL occur.
REQ-040 The first transfer SHALL occur on the first rising edge after rst_i deasserts.

Verification
REQ-041 The bench SHALL drive ADDI x5,x1,-1 (0xFFF08293) with rs1=7 and SHALL observe one cycle later: alu_op=0, rs1_data_o=7, rs2_data_o=0xFFFFFFFF, rd_addr_o=5, illegal_o=0.
REQ-042 The bench SHALL drive OP SUB (funct7=0100000, funct3=000) and SRAI shamt=31 (0x41F0D093) and SHALL observe alu_op=1, then alu_op=7 with rs2_data_o=31 and br_unsign_o=0.
REQ-043 The bench SHALL drive SLTU and SLTIU and SHALL observe alu_op=4, br_unsign_o=1; for SLTIU imm=0x800, rs2_data_o=0xFFFFF800.
REQ-044 The bench SHALL drive opcode 0000011 and OP funct7=0000001 and SHALL observe illegal_o=1, zeroed operands, and issue_cnt_o incremented.
REQ-045 The bench SHALL hold out_ready_i=0 for 3 cycles with in_valid_i=1 and SHALL observe in_ready_o=0 and stable outputs; on release it SHALL observe back-to-back transfers, one per cycle, with no drop or duplicate.
REQ-046 The bench SHALL preload issue_cnt_o near 0xFFFF by driving 65535 transfers, then one more, and SHALL observe 0x0000; it SHALL assert rst_i asynchronously mid-stall and observe out_valid_o=0 before the next edge.
